// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller with program counter, branch load,
// multi-word fetch and an MFC timeout that raises a sticky error flag.
module if_fetch_unit #(
  parameter int            AW       = 16,
  parameter int            WORDS    = 1,
  parameter int            TIMEOUT  = 15,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          MFC,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_addr,
  output logic [AW-1:0] pc,
  output logic          PC_Out,
  output logic          MAR_EN,
  output logic          mem_EN,
  output logic          mem_RW,
  output logic          MDR_EN_read,
  output logic          MDR_out,
  output logic          IR_EN,
  output logic [1:0]    ir_word_idx,
  output logic          busy,
  output logic          fetch_done,
  output logic          fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_MEM  = 3'd2,
    S_MDR  = 3'd3,
    S_IR   = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam logic [1:0] LAST_W = 2'(WORDS - 1);
  localparam logic [7:0] LAST_T = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    wait_q, wait_d;
  logic          err_q, err_d;

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      idx_q   <= 2'd0;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; an unused encoding falls back to idle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (branch_en) pc_d = branch_addr;
        if (start) begin
          err_d   = 1'b0;
          idx_d   = 2'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        wait_d  = 8'd0;
        state_d = S_MEM;
      end
      S_MEM: begin
        if (MFC)                   state_d = S_MDR;
        else if (wait_q == LAST_T) state_d = S_ERR;
        else                       wait_d  = wait_q + 8'd1;
      end
      S_MDR: state_d = S_IR;
      S_IR: begin
        pc_d = pc_q + AW'(1);
        if (idx_q == LAST_W) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_ADDR;
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore strobes decoded from the current state only.
  always_comb begin
    PC_Out      = 1'b0;
    MAR_EN      = 1'b0;
    mem_EN      = 1'b0;
    mem_RW      = 1'b0;
    MDR_EN_read = 1'b0;
    MDR_out     = 1'b0;
    IR_EN       = 1'b0;
    busy        = 1'b0;
    fetch_done  = 1'b0;
    case (state_q)
      S_ADDR: begin
        PC_Out = 1'b1;
        MAR_EN = 1'b1;
        busy   = 1'b1;
      end
      S_MEM: begin
        mem_EN = 1'b1;
        mem_RW = 1'b1;
        busy   = 1'b1;
      end
      S_MDR: begin
        mem_EN      = 1'b1;
        mem_RW      = 1'b1;
        MDR_EN_read = 1'b1;
        busy        = 1'b1;
      end
      S_IR: begin
        MDR_out = 1'b1;
        IR_EN   = 1'b1;
        busy    = 1'b1;
      end
      S_DONE: begin
        fetch_done = 1'b1;
        busy       = 1'b1;
      end
      S_ERR:   busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign pc          = pc_q;
  assign ir_word_idx = idx_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: two instances (1-word and 3-word, timeout 4)
// checked cycle by cycle against a transaction-level trace model.
module tb_if_fetch_unit;

  localparam int T = 4;
  localparam logic [9:0] V_IDLE = 10'b0000000000;
  localparam logic [9:0] V_ADDR = 10'b1100000100;
  localparam logic [9:0] V_MEM  = 10'b0011000100;
  localparam logic [9:0] V_MDR  = 10'b0011100100;
  localparam logic [9:0] V_IR   = 10'b0000011100;
  localparam logic [9:0] V_DONE = 10'b0000000110;
  localparam logic [9:0] V_ERR  = 10'b0000000100;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]  start, MFC, branch_en;
  logic [15:0] baddr [2];
  logic [15:0] pc_o [2];
  logic [1:0]  idx_o [2];
  logic [1:0]  PC_Out, MAR_EN, mem_EN, mem_RW, MDR_EN_read;
  logic [1:0]  MDR_out, IR_EN, busy, fetch_done, fetch_err;

  logic [15:0] mpc [2];
  logic [1:0]  midx [2];
  logic        merr [2];
  logic [15:0] rpc [2];
  int          nw [2];
  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .AW(16), .WORDS(1), .TIMEOUT(T), .RESET_PC(16'h0000)
  ) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .MFC(MFC[0]),
    .branch_en(branch_en[0]), .branch_addr(baddr[0]),
    .pc(pc_o[0]), .PC_Out(PC_Out[0]), .MAR_EN(MAR_EN[0]),
    .mem_EN(mem_EN[0]), .mem_RW(mem_RW[0]),
    .MDR_EN_read(MDR_EN_read[0]), .MDR_out(MDR_out[0]),
    .IR_EN(IR_EN[0]), .ir_word_idx(idx_o[0]), .busy(busy[0]),
    .fetch_done(fetch_done[0]), .fetch_err(fetch_err[0])
  );

  if_fetch_unit #(
    .AW(16), .WORDS(3), .TIMEOUT(T), .RESET_PC(16'h0100)
  ) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .MFC(MFC[1]),
    .branch_en(branch_en[1]), .branch_addr(baddr[1]),
    .pc(pc_o[1]), .PC_Out(PC_Out[1]), .MAR_EN(MAR_EN[1]),
    .mem_EN(mem_EN[1]), .mem_RW(mem_RW[1]),
    .MDR_EN_read(MDR_EN_read[1]), .MDR_out(MDR_out[1]),
    .IR_EN(IR_EN[1]), .ir_word_idx(idx_o[1]), .busy(busy[1]),
    .fetch_done(fetch_done[1]), .fetch_err(fetch_err[1])
  );

  function automatic logic [9:0] obs(input int u);
    return {PC_Out[u], MAR_EN[u], mem_EN[u], mem_RW[u],
            MDR_EN_read[u], MDR_out[u], IR_EN[u],
            busy[u], fetch_done[u], fetch_err[u]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int u, input logic [9:0] v, input string tag);
    logic [9:0] ev;
    ev = v | {9'd0, merr[u]};
    nvec++;
    assert (obs(u) === ev) else begin
      nbad++;
      $error("FAIL %s u%0d strobes obs=%b exp=%b", tag, u, obs(u), ev);
    end
    nvec++;
    assert (pc_o[u] === mpc[u]) else begin
      nbad++;
      $error("FAIL %s u%0d pc obs=%h exp=%h", tag, u, pc_o[u], mpc[u]);
    end
    nvec++;
    assert (idx_o[u] === midx[u]) else begin
      nbad++;
      $error("FAIL %s u%0d idx obs=%0d exp=%0d", tag, u, idx_o[u], midx[u]);
    end
  endtask

  task automatic noise(input int u);
    start[u]     = 1'($urandom);
    branch_en[u] = 1'($urandom);
    baddr[u]     = 16'($urandom);
    MFC[u]       = 1'($urandom);
  endtask

  task automatic quiet(input int u);
    start[u]     = 1'b0;
    branch_en[u] = 1'b0;
    MFC[u]       = 1'b0;
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      mpc[u]  = rpc[u];
      midx[u] = 2'd0;
      merr[u] = 1'b0;
    end
  endtask

  // One fetch; d[w] is the number of S_MEM wait cycles before MFC
  // on word w, a value >= T means MFC never arrives.
  task automatic fetch(input int u, input int d[4],
                       input bit br, input logic [15:0] ba);
    bit failed;
    failed = 1'b0;
    start[u] = 1'b1;
    branch_en[u] = br;
    baddr[u] = ba;
    MFC[u] = 1'b1;
    step();
    if (br) mpc[u] = ba;
    merr[u] = 1'b0;
    for (int w = 0; w < nw[u]; w++) begin
      midx[u] = 2'(w);
      check(u, V_ADDR, "addr");
      noise(u);
      step();
      for (int c = 0; c < T; c++) begin
        check(u, V_MEM, "mem");
        noise(u);
        MFC[u] = (c == d[w]);
        step();
        if (c == d[w]) break;
      end
      if (d[w] >= T) begin
        failed = 1'b1;
        check(u, V_ERR, "err");
        noise(u);
        step();
        merr[u] = 1'b1;
        break;
      end
      check(u, V_MDR, "mdr");
      noise(u);
      step();
      check(u, V_IR, "ir");
      noise(u);
      step();
      mpc[u] = mpc[u] + 16'd1;
    end
    if (!failed) begin
      check(u, V_DONE, "done");
      noise(u);
      step();
    end
    check(u, V_IDLE, "idle");
    quiet(u);
  endtask

  initial begin
    int d[4];
    rpc[0] = 16'h0000;
    rpc[1] = 16'h0100;
    nw[0] = 1;
    nw[1] = 3;
    rst = 1'b1;
    quiet(0);
    quiet(1);
    baddr[0] = 16'h0;
    baddr[1] = 16'h0;
    model_reset();
    step();
    step();
    check(0, V_IDLE, "reset");
    check(1, V_IDLE, "reset");
    rst = 1'b0;
    step();

    // single word, MFC at once, then pc 0 -> 1
    d = '{0, 0, 0, 0};
    fetch(0, d, 1'b0, 16'h0);
    // three words, two wait cycles each
    d = '{2, 2, 2, 0};
    fetch(1, d, 1'b0, 16'h0);
    // timeout, then recovery clears the flag
    d = '{T, 0, 0, 0};
    fetch(0, d, 1'b0, 16'h0);
    d = '{0, 0, 0, 0};
    fetch(0, d, 1'b0, 16'h0);
    // MFC on the last allowed cycle
    d = '{T - 1, 0, 0, 0};
    fetch(0, d, 1'b0, 16'h0);
    // branch to top of memory and wrap
    d = '{1, 0, 0, 0};
    fetch(0, d, 1'b1, 16'hFFFF);
    d = '{0, 1, 3, 0};
    fetch(1, d, 1'b1, 16'hFFFE);
    // timeout on a middle word keeps earlier increments
    d = '{0, T + 1, 0, 0};
    fetch(1, d, 1'b0, 16'h0);

    // randomized fetches and idle-time branch loads
    for (int i = 0; i < 60; i++) begin
      int u;
      u = int'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) d[k] = int'($urandom_range(0, T + 1));
      if ($urandom_range(0, 3) == 0) begin
        baddr[u] = 16'($urandom);
        branch_en[u] = 1'b1;
        step();
        mpc[u] = baddr[u];
        branch_en[u] = 1'b0;
        check(u, V_IDLE, "brload");
      end
      fetch(u, d, 1'($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom));
    end

    // async reset in the middle of a memory wait
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    model_reset();
    check(0, V_IDLE, "rstmid");
    check(1, V_IDLE, "rstmid");
    step();
    rst = 1'b0;
    step();
    check(1, V_IDLE, "postrst");
    d = '{0, 0, 0, 0};
    fetch(1, d, 1'b0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
